// File: rtl/q_updater_multi_if.sv
// q_updater_multi_if: handshake and data bundle for the Q-learning update engine.
//   master : transaction source / result sink (policy side)
//   slave  : the update engine
// Signals:
//   in_valid/in_ready    transaction handshake
//   q_in                 Q-values, agent i action j at [(i*N_ACT+j)*DATA_W +: DATA_W]
//   act_in, reward       action taken and reward per agent
//   alpha, gamma         unsigned learning rate / discount, 1.0 = 2^FRAC_W
//   out_valid/out_ready  result handshake
//   qnew_out, amax_out   updated Q[a] and greedy action per agent
//   sat_out              per-agent saturation flag of the final add
//   busy                 engine not idle
interface q_updater_multi_if #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 16,
  parameter int N_AGENT = 2,
  parameter int N_ACT   = 4
);
  localparam int ACT_W = (N_ACT > 1) ? $clog2(N_ACT) : 1;

  logic                            in_valid;
  logic                            in_ready;
  logic [N_AGENT*N_ACT*DATA_W-1:0] q_in;
  logic [N_AGENT*ACT_W-1:0]        act_in;
  logic [N_AGENT*DATA_W-1:0]       reward;
  logic [FRAC_W:0]                 alpha;
  logic [FRAC_W:0]                 gamma;
  logic                            out_valid;
  logic                            out_ready;
  logic [N_AGENT*DATA_W-1:0]       qnew_out;
  logic [N_AGENT*ACT_W-1:0]        amax_out;
  logic [N_AGENT-1:0]              sat_out;
  logic                            busy;

  modport master (
    output in_valid, q_in, act_in, reward, alpha, gamma, out_ready,
    input  in_ready, out_valid, qnew_out, amax_out, sat_out, busy
  );

  modport slave (
    input  in_valid, q_in, act_in, reward, alpha, gamma, out_ready,
    output in_ready, out_valid, qnew_out, amax_out, sat_out, busy
  );
endinterface

// File: rtl/q_updater_multi.sv
// q_updater_multi: time-multiplexed Q-learning update engine.
// For each agent i: Qnew = Q[a] + alpha*(R + gamma*max(Q) - Q[a]), using one
// shared multiplier (gamma*q_max in MUL_G, alpha*td in UPD). Results for all
// agents are presented together once the last agent finishes.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  q_updater_multi_if.slave (handshakes, operands, results, busy)
// Optional build macro QUPD_ROUND_EN: both >>> FRAC_W shifts round half-up
// instead of truncating toward negative infinity.
//
// state | meaning
// IDLE  | waiting for a transaction
// MUL_G | agent i: pick q_sa / q_max / amax, t1 = gamma*q_max
// DIFF  | agent i: td = R + t1 - q_sa
// UPD   | agent i: qnew = sat(q_sa + alpha*td), next agent or DONE
// DONE  | results valid, held until out_ready
module q_updater_multi #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 16,
  parameter int N_AGENT = 2,
  parameter int N_ACT   = 4
) (
  input logic               clk,
  input logic               rst,
  q_updater_multi_if.slave  bus
);
  localparam int ACT_W = (N_ACT > 1) ? $clog2(N_ACT) : 1;
  localparam int CNT_W = (N_AGENT > 1) ? $clog2(N_AGENT) : 1;
  localparam int AW    = DATA_W + 3;
  localparam int PW    = DATA_W + FRAC_W + 5;
  localparam int SW    = DATA_W + 5;
  localparam logic [FRAC_W:0]       ONE  = (FRAC_W+1)'(1) << FRAC_W;
  localparam logic signed [SW-1:0]  SMAX = SW'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [SW-1:0]  SMIN = -SMAX - SW'(1);

  typedef enum logic [2:0] {IDLE, MUL_G, DIFF, UPD, DONE} state_t;
  state_t state;

  logic [N_AGENT*N_ACT*DATA_W-1:0] q_l;
  logic [N_AGENT*ACT_W-1:0]        act_l;
  logic [N_AGENT*DATA_W-1:0]       r_l;
  logic [FRAC_W:0]                 alpha_l, gamma_l;
  logic [CNT_W-1:0]                cnt;
  logic signed [DATA_W:0]          t1;
  logic signed [AW-1:0]            td;

  int                       base;
  logic [ACT_W-1:0]         act_sel, idx_sa, max_idx;
  logic signed [DATA_W-1:0] q_sa, q_max, r_i, q_sat;
  logic signed [AW-1:0]     mul_a;
  logic signed [FRAC_W+1:0] mul_b;
  logic signed [PW-1:0]     prod, prod_r, shifted;
  logic signed [SW-1:0]     sum;
  logic                     sat_hi, sat_lo, accept;

  assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.busy     = (state != IDLE);
  assign accept       = bus.in_valid && bus.in_ready;

  // Operand selection for the current agent; strict '>' keeps the lowest index on ties.
  always_comb begin
    base    = int'(cnt) * N_ACT;
    act_sel = act_l[int'(cnt)*ACT_W +: ACT_W];
    idx_sa  = (int'(act_sel) < N_ACT) ? act_sel : '0;
    q_sa    = q_l[(base + int'(idx_sa))*DATA_W +: DATA_W];
    q_max   = q_l[base*DATA_W +: DATA_W];
    max_idx = '0;
    for (int j = 1; j < N_ACT; j++) begin
      if ($signed(q_l[(base+j)*DATA_W +: DATA_W]) > q_max) begin
        q_max   = q_l[(base+j)*DATA_W +: DATA_W];
        max_idx = ACT_W'(j);
      end
    end
    r_i = r_l[int'(cnt)*DATA_W +: DATA_W];
  end

  // Shared multiplier: gamma*q_max outside UPD, alpha*td in UPD.
  always_comb begin
    mul_a = (state == UPD) ? td : AW'(q_max);
    mul_b = $signed({1'b0, (state == UPD) ? alpha_l : gamma_l});
    prod  = mul_a * mul_b;
`ifdef QUPD_ROUND_EN
    prod_r = prod + (PW'(1) << (FRAC_W-1));
`else
    prod_r = prod;
`endif
    shifted = prod_r >>> FRAC_W;
    sum     = SW'(q_sa) + SW'(shifted);
    sat_hi  = (sum > SMAX);
    sat_lo  = (sum < SMIN);
    q_sat   = sat_hi ? SMAX[DATA_W-1:0] : (sat_lo ? SMIN[DATA_W-1:0] : sum[DATA_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      q_l          <= '0;
      act_l        <= '0;
      r_l          <= '0;
      alpha_l      <= '0;
      gamma_l      <= '0;
      t1           <= '0;
      td           <= '0;
      bus.out_valid <= 1'b0;
      bus.qnew_out <= '0;
      bus.amax_out <= '0;
      bus.sat_out  <= '0;
    end else begin
      if (state == DONE && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        state         <= IDLE;
      end
      if (accept) begin
        q_l     <= bus.q_in;
        act_l   <= bus.act_in;
        r_l     <= bus.reward;
        alpha_l <= (bus.alpha > ONE) ? ONE : bus.alpha;
        gamma_l <= (bus.gamma > ONE) ? ONE : bus.gamma;
        cnt     <= '0;
        state   <= MUL_G;
      end
      case (state)
        MUL_G: begin
          t1 <= (DATA_W+1)'(shifted);
          bus.amax_out[int'(cnt)*ACT_W +: ACT_W] <= max_idx;
          state <= DIFF;
        end
        DIFF: begin
          td    <= AW'(r_i) + AW'(t1) - AW'(q_sa);
          state <= UPD;
        end
        UPD: begin
          bus.qnew_out[int'(cnt)*DATA_W +: DATA_W] <= q_sat;
          bus.sat_out[cnt] <= sat_hi || sat_lo;
          if (cnt == CNT_W'(N_AGENT-1)) begin
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= MUL_G;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_q_updater_multi.sv
module tb_q_updater_multi;
  localparam int DATA_W  = 32;
  localparam int FRAC_W  = 16;
  localparam int N_AGENT = 2;
  localparam int N_ACT   = 4;
  localparam int ACT_W   = 2;
  localparam int QW      = N_AGENT*N_ACT*DATA_W;
`ifdef QUPD_ROUND_EN
  localparam longint RND_EXP = 1;
`else
  localparam longint RND_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  q_updater_multi_if #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_AGENT(N_AGENT), .N_ACT(N_ACT)) bus ();

  q_updater_multi #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_AGENT(N_AGENT), .N_ACT(N_ACT)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint shr(input longint x);
`ifdef QUPD_ROUND_EN
    return (x + (64'sd1 <<< (FRAC_W-1))) >>> FRAC_W;
`else
    return x >>> FRAC_W;
`endif
  endfunction

  function automatic void ref_agent(input int i, output longint qn, output longint am, output longint st);
    longint q[N_ACT];
    longint qsa, qmax, r, al, ga, t1, td, sum;
    int a;
    for (int j = 0; j < N_ACT; j++)
      q[j] = longint'($signed(bus.q_in[(i*N_ACT+j)*DATA_W +: DATA_W]));
    a = int'(bus.act_in[i*ACT_W +: ACT_W]);
    if (a >= N_ACT) a = 0;
    qsa = q[a];
    qmax = q[0]; am = 0;
    for (int j = 1; j < N_ACT; j++) if (q[j] > qmax) begin qmax = q[j]; am = j; end
    r  = longint'($signed(bus.reward[i*DATA_W +: DATA_W]));
    al = longint'(bus.alpha); if (al > 65536) al = 65536;
    ga = longint'(bus.gamma); if (ga > 65536) ga = 65536;
    t1 = shr(ga * qmax);
    td = r + t1 - qsa;
    sum = qsa + shr(al * td);
    st = 0;
    if (sum > 64'sh7FFFFFFF) begin sum = 64'sh7FFFFFFF; st = 1; end
    if (sum < -64'sh80000000) begin sum = -64'sh80000000; st = 1; end
    qn = sum & 64'hFFFFFFFF;
  endfunction

  // Timeline model: results appear 3*N_AGENT edges after acceptance.
  int     m_cnt = 0;
  bit     m_valid = 0, m_known = 1;
  longint e_q[N_AGENT], e_a[N_AGENT], e_s[N_AGENT];
  longint p_q[N_AGENT], p_a[N_AGENT], p_s[N_AGENT];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_valid = 0; m_known = 1;
        for (int i = 0; i < N_AGENT; i++) begin e_q[i] = 0; e_a[i] = 0; e_s[i] = 0; end
      end else begin
        bit acc;
        acc = bus.in_valid && ((m_cnt == 0 && !m_valid) || (m_valid && bus.out_ready));
        if (m_valid && bus.out_ready) m_valid = 0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_valid = 1; m_known = 1;
            e_q = p_q; e_a = p_a; e_s = p_s;
          end
        end
        if (acc) begin
          for (int i = 0; i < N_AGENT; i++) ref_agent(i, p_q[i], p_a[i], p_s[i]);
          m_cnt = 3*N_AGENT; m_known = 0;
        end
      end
    end
  end

  // Compare process.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", longint'(bus.out_valid), longint'(m_valid));
      chk("busy", longint'(bus.busy), longint'(m_cnt > 0 || m_valid));
      chk("in_ready", longint'(bus.in_ready),
          longint'((m_cnt == 0 && !m_valid) || (m_valid && bus.out_ready)));
      if (m_known) begin
        for (int i = 0; i < N_AGENT; i++) begin
          chk("qnew", longint'(bus.qnew_out[i*DATA_W +: DATA_W]), e_q[i]);
          chk("amax", longint'(bus.amax_out[i*ACT_W +: ACT_W]), e_a[i]);
          chk("sat", longint'(bus.sat_out[i]), e_s[i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [N_ACT*DATA_W-1:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic load(input logic [QW-1:0] q, input logic [N_AGENT*ACT_W-1:0] a,
                      input logic [N_AGENT*DATA_W-1:0] r, input logic [FRAC_W:0] al, ga);
    bus.q_in = q; bus.act_in = a; bus.reward = r; bus.alpha = al; bus.gamma = ga;
  endtask

  task automatic accept_txn();
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 20);
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (!bus.out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [QW-1:0] q_basic, q_sat, q_rnd, q_tie;
  logic [N_AGENT*DATA_W-1:0] r_basic;
  logic [N_AGENT*DATA_W-1:0] held;

  initial begin
    int cyc;
    q_basic = {pk(32'h20000, 32'h30000, 32'h40000, 32'h70000), pk(32'h10000, 32'h20000, 32'h30000, 32'h40000)};
    r_basic = {32'hFFF60000, 32'hFFF60000};
    q_sat   = {8{32'h7FFF0000}};
    q_rnd   = {8{32'h00000001}};
    q_tie   = {8{32'h00050000}};
    bus.in_valid = 0; bus.out_ready = 0;
    load('0, '0, '0, '0, '0);
    #3;
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_qnew", longint'(bus.qnew_out), 0);
    #19 rst_n = 1'b1;

    // Basic update: agent A a=1, agent B a=2.
    load(q_basic, 4'b1001, r_basic, 17'h04000, 17'h0C000);
    accept_txn();
    wait_valid(cyc);
    chk("basic_latency", cyc, 6);
    chk("basic_qA", longint'(bus.qnew_out[31:0]), 64'hFFFFC000);
    chk("basic_qB", longint'(bus.qnew_out[63:32]), 64'h0001D000);
    chk("basic_amax", longint'(bus.amax_out), 64'hF);
    chk("basic_sat", longint'(bus.sat_out), 0);
    consume();

    // Input hold: operands scrambled every cycle after acceptance.
    load(q_basic, 4'b1001, r_basic, 17'h04000, 17'h0C000);
    accept_txn();
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      bus.q_in = ~bus.q_in; bus.act_in = bus.act_in + 1'b1;
      bus.reward = bus.reward + 64'h10000; bus.alpha = ~bus.alpha;
      @(posedge clk); #1; cyc++;
    end
    chk("hold_qA", longint'(bus.qnew_out[31:0]), 64'hFFFFC000);
    chk("hold_qB", longint'(bus.qnew_out[63:32]), 64'h0001D000);
    consume();

    // Saturation.
    load(q_sat, 4'b0000, {2{32'h7FFF0000}}, 17'h10000, 17'h10000);
    accept_txn();
    wait_valid(cyc);
    chk("sat_q", longint'(bus.qnew_out), 64'h7FFFFFFF7FFFFFFF);
    chk("sat_flag", longint'(bus.sat_out), 3);
    consume();

    // Rounding.
    load(q_rnd, 4'b0000, '0, 17'h10000, 17'h08000);
    accept_txn();
    wait_valid(cyc);
    chk("round_qA", longint'(bus.qnew_out[31:0]), RND_EXP);
    consume();

    // Backpressure then back-to-back accept.
    load(q_basic, 4'b1001, r_basic, 17'h04000, 17'h0C000);
    accept_txn();
    wait_valid(cyc);
    held = bus.qnew_out;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", longint'(bus.in_ready), 0);
      chk("bp_stable", longint'(bus.qnew_out), longint'(held));
    end
    @(posedge clk); #1;
    load(q_sat, 4'b0000, {2{32'h7FFF0000}}, 17'h10000, 17'h10000);
    bus.out_ready = 1; bus.in_valid = 1;
    @(negedge clk);
    chk("b2b_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.out_ready = 0; bus.in_valid = 0;
    wait_valid(cyc);
    chk("b2b_latency", cyc, 6);
    chk("b2b_q", longint'(bus.qnew_out), 64'h7FFFFFFF7FFFFFFF);
    consume();

    // Ties.
    load(q_tie, 4'b1111, '0, 17'h08000, 17'h08000);
    accept_txn();
    wait_valid(cyc);
    chk("tie_amax", longint'(bus.amax_out), 0);
    consume();

    // Reset during DIFF of agent 1.
    load(q_basic, 4'b1001, r_basic, 17'h04000, 17'h0C000);
    accept_txn();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_qnew", longint'(bus.qnew_out), 0);
    chk("rst_mid_amax", longint'(bus.amax_out), 0);
    chk("rst_mid_busy", longint'(bus.busy), 0);
    chk("rst_mid_valid", longint'(bus.out_valid), 0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_in_ready", longint'(bus.in_ready), 1);

    // Randomized traffic checked by the model every cycle.
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 2) == 0);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      for (int w = 0; w < N_AGENT*N_ACT; w++) begin
        if ($urandom_range(0, 3) == 0) bus.q_in[w*DATA_W +: DATA_W] = $urandom;
        else bus.q_in[w*DATA_W +: DATA_W] = 32'(($urandom_range(0, 6) - 3) * 65536);
      end
      bus.act_in = 4'($urandom);
      for (int i = 0; i < N_AGENT; i++) bus.reward[i*DATA_W +: DATA_W] = $urandom;
      bus.alpha = 17'($urandom_range(0, 17'h1FFFF));
      bus.gamma = 17'($urandom_range(0, 17'h1FFFF));
    end
    bus.in_valid = 0; bus.out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
endmodule
